// File: rtl/usb_tx_sched_if.sv
// rtl/usb_tx_sched_if.sv - requester and transmit handshake bundle for usb_tx_sched
//
// Purpose: groups the per-requester beat handshake and the shared transmit
//          handshake so that the scheduler and its environment share one bundle.
// Signals:
//   req        per-requester beat valid
//   req_data   requester i drives bits [i*DATA_W +: DATA_W]
//   req_last   per-requester final beat of packet
//   req_ready  beat accepted from the granted requester
//   tx_valid   beat valid to the transmit datapath
//   tx_data    beat data
//   tx_last    final beat of the transmitted packet
//   tx_ready   transmit datapath accepts the beat
// Modports: master = scheduler side, slave = sources/transmit environment side.
interface usb_tx_sched_if #(
   parameter int NREQ   = 4,
   parameter int DATA_W = 8
);
   logic [NREQ-1:0]        req;
   logic [NREQ*DATA_W-1:0] req_data;
   logic [NREQ-1:0]        req_last;
   logic [NREQ-1:0]        req_ready;
   logic                   tx_valid;
   logic [DATA_W-1:0]      tx_data;
   logic                   tx_last;
   logic                   tx_ready;

   modport master (
      input  req, req_data, req_last, tx_ready,
      output req_ready, tx_valid, tx_data, tx_last
   );

   modport slave (
      output req, req_data, req_last, tx_ready,
      input  req_ready, tx_valid, tx_data, tx_last
   );
endinterface

// File: rtl/usb_tx_sched.sv
// rtl/usb_tx_sched.sv - round-robin packet scheduler for the shared USB transmit datapath
//
// Purpose: locks the transmit datapath to one requester for a whole packet,
//          truncates packets at MAX_BEATS beats and inserts GAP_CYCLES idle
//          cycles between packets. Arbitration is round-robin from a pointer
//          that moves past the requester that was last served.
// Ports:
//   clk      clock, rising edge
//   reset    asynchronous active-high reset
//   bus      usb_tx_sched_if.master (req/req_data/req_last/req_ready, tx_*)
//   grant    one-hot registered grant, zero when idle
//   busy     high in XFER and GAP
//   overlen  one-cycle pulse in the first GAP cycle after a truncated packet
//   abort    one-cycle pulse in the first GAP cycle after a stall timeout
// Optional feature: define USB_TX_SCHED_TIMEOUT_EN to build the stall counter;
//          otherwise abort is tied 0 and XFER waits indefinitely.
module usb_tx_sched #(
   parameter int NREQ       = 4,
   parameter int DATA_W     = 8,
   parameter int MAX_BEATS  = 16,
   parameter int GAP_CYCLES = 2,
   parameter int TIMEOUT    = 64
) (
   input  logic            clk,
   input  logic            reset,
   usb_tx_sched_if.master  bus,
   output logic [NREQ-1:0] grant,
   output logic            busy,
   output logic            overlen,
   output logic            abort
);
   localparam int IW = $clog2(NREQ);
   localparam int BW = $clog2(MAX_BEATS);

   typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

   state_t          state, state_nxt;
   logic [IW-1:0]   ptr, ptr_nxt;
   logic [IW-1:0]   gidx, gidx_nxt;
   logic [NREQ-1:0] grant_nxt;
   logic [BW-1:0]   beat_cnt, beat_cnt_nxt;
   logic [7:0]      gap_cnt, gap_cnt_nxt;
   logic            overlen_nxt;
   logic [IW-1:0]   sel_idx;
   logic            sel_found;
   logic            beat_xfer;
   logic            pkt_end;
   logic [IW-1:0]   ptr_adv;

`ifdef USB_TX_SCHED_TIMEOUT_EN
   localparam int SW = $clog2(TIMEOUT + 1);
   logic [SW-1:0] stall_cnt, stall_cnt_nxt;
   logic          abort_nxt;
`else
   // TIMEOUT only matters when the stall counter is built.
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT > 0);
   assign abort = 1'b0;
`endif

   assign busy    = (state != IDLE);
   assign ptr_adv = (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;

   // First requesting port at or after the pointer, wrapping around.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!sel_found && bus.req[(int'(ptr) + k) % NREQ]) begin
            sel_found = 1'b1;
            sel_idx   = IW'((int'(ptr) + k) % NREQ);
         end
      end
   end

   always_comb begin
      state_nxt     = state;
      grant_nxt     = grant;
      gidx_nxt      = gidx;
      ptr_nxt       = ptr;
      beat_cnt_nxt  = beat_cnt;
      gap_cnt_nxt   = gap_cnt;
      overlen_nxt   = 1'b0;
      beat_xfer     = 1'b0;
      pkt_end       = 1'b0;
      bus.tx_valid  = 1'b0;
      bus.tx_data   = '0;
      bus.tx_last   = 1'b0;
      bus.req_ready = '0;
`ifdef USB_TX_SCHED_TIMEOUT_EN
      stall_cnt_nxt = stall_cnt;
      abort_nxt     = 1'b0;
`endif
      case (state)
         IDLE: begin
`ifdef USB_TX_SCHED_TIMEOUT_EN
            stall_cnt_nxt = '0;
`endif
            if (sel_found) begin
               state_nxt    = XFER;
               gidx_nxt     = sel_idx;
               grant_nxt    = NREQ'(1) << sel_idx;
               beat_cnt_nxt = '0;
            end
         end
         XFER: begin
            bus.tx_valid        = bus.req[gidx];
            bus.tx_data         = bus.req_data[int'(gidx)*DATA_W +: DATA_W];
            bus.tx_last         = bus.req_last[gidx] | (beat_cnt == BW'(MAX_BEATS - 1));
            bus.req_ready[gidx] = bus.tx_ready;
            beat_xfer           = bus.req[gidx] & bus.tx_ready;
            if (beat_xfer) begin
               beat_cnt_nxt = beat_cnt + 1'b1;
`ifdef USB_TX_SCHED_TIMEOUT_EN
               stall_cnt_nxt = '0;
`endif
               if (bus.tx_last) begin
                  pkt_end     = 1'b1;
                  // Forced last without the source's last means truncation.
                  overlen_nxt = ~bus.req_last[gidx];
               end
            end
`ifdef USB_TX_SCHED_TIMEOUT_EN
            else begin
               stall_cnt_nxt = stall_cnt + 1'b1;
               if (stall_cnt_nxt == SW'(TIMEOUT)) begin
                  pkt_end   = 1'b1;
                  abort_nxt = 1'b1;
               end
            end
`endif
            if (pkt_end) begin
               state_nxt   = GAP;
               grant_nxt   = '0;
               ptr_nxt     = ptr_adv;
               gap_cnt_nxt = 8'(GAP_CYCLES);
            end
         end
         GAP: begin
            gap_cnt_nxt = gap_cnt - 1'b1;
            if (gap_cnt == 8'd1) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         grant     <= '0;
         gidx      <= '0;
         ptr       <= '0;
         beat_cnt  <= '0;
         gap_cnt   <= '0;
         overlen   <= 1'b0;
`ifdef USB_TX_SCHED_TIMEOUT_EN
         stall_cnt <= '0;
         abort     <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         grant     <= grant_nxt;
         gidx      <= gidx_nxt;
         ptr       <= ptr_nxt;
         beat_cnt  <= beat_cnt_nxt;
         gap_cnt   <= gap_cnt_nxt;
         overlen   <= overlen_nxt;
`ifdef USB_TX_SCHED_TIMEOUT_EN
         stall_cnt <= stall_cnt_nxt;
         abort     <= abort_nxt;
`endif
      end
   end
endmodule

// File: tb/tb_usb_tx_sched.sv
// tb/tb_usb_tx_sched.sv - directed self-checking bench for usb_tx_sched
module tb_usb_tx_sched;
   localparam int NREQ   = 4;
   localparam int DATA_W = 8;

   logic            clk = 1'b0;
   logic            reset;
   logic [NREQ-1:0] grant;
   logic            busy;
   logic            overlen;
   logic            abort;
   int              n_checks = 0;
   int              n_errors = 0;

   usb_tx_sched_if #(.NREQ(NREQ), .DATA_W(DATA_W)) bus ();

   usb_tx_sched #(
      .NREQ(NREQ), .DATA_W(DATA_W), .MAX_BEATS(4), .GAP_CYCLES(2), .TIMEOUT(8)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .grant(grant), .busy(busy), .overlen(overlen), .abort(abort)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic setd(input int p, input logic [7:0] d, input logic last);
      bus.req_data[p*DATA_W +: DATA_W] = d;
      bus.req_last[p] = last;
   endtask

   task automatic beat(input int p, input logic [7:0] d, input logic last,
                       input logic exp_last, input string tag);
      setd(p, d, last);
      #1;
      check({tag, "_grant"}, grant, 32'(1 << p));
      check({tag, "_valid"}, bus.tx_valid, 1);
      check({tag, "_data"}, bus.tx_data, d);
      check({tag, "_last"}, bus.tx_last, exp_last);
      check({tag, "_ready"}, bus.req_ready, 32'(1 << p));
      cyc();
   endtask

   task automatic gap_chk(input logic exp_ov, input string tag);
      #1;
      check({tag, "_gap1_busy"}, busy, 1);
      check({tag, "_gap1_grant"}, grant, 0);
      check({tag, "_gap1_valid"}, bus.tx_valid, 0);
      check({tag, "_gap1_overlen"}, overlen, exp_ov);
      cyc();
      check({tag, "_gap2_busy"}, busy, 1);
      check({tag, "_gap2_overlen"}, overlen, 0);
      cyc();
      check({tag, "_idle_busy"}, busy, 0);
   endtask

   initial begin
      reset        = 1'b1;
      bus.req      = '0;
      bus.req_data = '0;
      bus.req_last = '0;
      bus.tx_ready = 1'b0;
      #1;
      check("rst_grant", grant, 0);
      check("rst_busy", busy, 0);
      check("rst_valid", bus.tx_valid, 0);
      check("rst_ready", bus.req_ready, 0);
      check("rst_overlen", overlen, 0);
      check("rst_abort", abort, 0);
      cyc();
      reset = 1'b0;

      // Single requester, 3 beats
      bus.req      = 4'b0001;
      bus.tx_ready = 1'b1;
      setd(0, 8'hA1, 1'b0);
      #1;
      check("s_idle_valid", bus.tx_valid, 0);
      check("s_idle_grant", grant, 0);
      cyc();
      beat(0, 8'hA1, 1'b0, 1'b0, "s1");
      beat(0, 8'hA2, 1'b0, 1'b0, "s2");
      beat(0, 8'hA3, 1'b1, 1'b1, "s3");
      bus.req = 4'b0000;
      setd(0, 8'h00, 1'b0);
      gap_chk(1'b0, "s");

      // Return pointer to 0
      reset = 1'b1;
      cyc();
      reset = 1'b0;

      // Fairness between ports 0 and 2
      bus.req = 4'b0101;
      setd(0, 8'h10, 1'b0);
      setd(2, 8'h20, 1'b0);
      cyc();
      beat(0, 8'h10, 1'b0, 1'b0, "f0a");
      beat(0, 8'h11, 1'b1, 1'b1, "f0b");
      setd(0, 8'h12, 1'b0);
      gap_chk(1'b0, "f0");
      cyc();
      beat(2, 8'h20, 1'b0, 1'b0, "f2a");
      beat(2, 8'h21, 1'b1, 1'b1, "f2b");
      setd(2, 8'h22, 1'b0);
      gap_chk(1'b0, "f2");
      cyc();
      beat(0, 8'h12, 1'b0, 1'b0, "f0c");
      beat(0, 8'h13, 1'b1, 1'b1, "f0d");
      setd(0, 8'h00, 1'b0);
      gap_chk(1'b0, "f0x");
      cyc();
      beat(2, 8'h22, 1'b0, 1'b0, "f2c");
      beat(2, 8'h23, 1'b1, 1'b1, "f2d");
      bus.req = 4'b0000;
      setd(2, 8'h00, 1'b0);
      gap_chk(1'b0, "f2x");

      // Backpressure on port 1 (pointer at 3 wraps to 1)
      bus.req = 4'b0010;
      setd(1, 8'h30, 1'b0);
      cyc();
      beat(1, 8'h30, 1'b0, 1'b0, "bp0");
      setd(1, 8'h31, 1'b0);
      bus.tx_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("bp_stall_valid", bus.tx_valid, 1);
         check("bp_stall_data", bus.tx_data, 8'h31);
         check("bp_stall_ready", bus.req_ready, 0);
         check("bp_stall_last", bus.tx_last, 0);
         cyc();
      end
      bus.tx_ready = 1'b1;
      beat(1, 8'h31, 1'b0, 1'b0, "bp1");
      beat(1, 8'h32, 1'b0, 1'b0, "bp2");
      beat(1, 8'h33, 1'b1, 1'b1, "bp3");
      bus.req = 4'b0000;
      setd(1, 8'h00, 1'b0);
      gap_chk(1'b0, "bp");

      // Reset mid-packet on port 2, then arbitration from pointer 0
      bus.req = 4'b0100;
      setd(2, 8'h50, 1'b0);
      cyc();
      beat(2, 8'h50, 1'b0, 1'b0, "rm0");
      beat(2, 8'h51, 1'b0, 1'b0, "rm1");
      setd(2, 8'h52, 1'b0);
      #1;
      check("rm_pre_valid", bus.tx_valid, 1);
      reset = 1'b1;
      #1;
      check("rm_grant", grant, 0);
      check("rm_valid", bus.tx_valid, 0);
      check("rm_busy", busy, 0);
      check("rm_last", bus.tx_last, 0);
      check("rm_ready", bus.req_ready, 0);
      bus.req = 4'b1010;
      setd(1, 8'h60, 1'b1);
      setd(2, 8'h00, 1'b0);
      setd(3, 8'h70, 1'b0);
      cyc();
      reset = 1'b0;
      cyc();
      beat(1, 8'h60, 1'b1, 1'b1, "rs");
      bus.req = 4'b0000;
      setd(1, 8'h00, 1'b0);
      gap_chk(1'b0, "rs");

      // Truncation: 6 beats without last, MAX_BEATS = 4
      bus.req = 4'b1000;
      setd(3, 8'h40, 1'b0);
      cyc();
      beat(3, 8'h40, 1'b0, 1'b0, "tr0");
      beat(3, 8'h41, 1'b0, 1'b0, "tr1");
      beat(3, 8'h42, 1'b0, 1'b0, "tr2");
      beat(3, 8'h43, 1'b0, 1'b1, "tr3");
      setd(3, 8'h44, 1'b0);
      gap_chk(1'b1, "tr");
      cyc();
      beat(3, 8'h44, 1'b0, 1'b0, "tr4");
      beat(3, 8'h45, 1'b1, 1'b1, "tr5");
      bus.req = 4'b0000;
      setd(3, 8'h00, 1'b0);
      gap_chk(1'b0, "tr2");

      // Stall with req[g] low after one beat
      bus.req = 4'b0001;
      setd(0, 8'h80, 1'b0);
      cyc();
      beat(0, 8'h80, 1'b0, 1'b0, "to0");
      bus.req = 4'b0000;
`ifdef USB_TX_SCHED_TIMEOUT_EN
      for (int i = 0; i < 8; i++) begin
         #1;
         check("to_stall_grant", grant, 1);
         check("to_stall_valid", bus.tx_valid, 0);
         check("to_stall_abort", abort, 0);
         check("to_stall_busy", busy, 1);
         cyc();
      end
      check("to_abort", abort, 1);
      check("to_abort_busy", busy, 1);
      check("to_abort_grant", grant, 0);
      check("to_abort_last", bus.tx_last, 0);
      bus.req = 4'b0011;
      setd(0, 8'h00, 1'b0);
      setd(1, 8'h90, 1'b1);
      cyc();
      check("to_abort_clear", abort, 0);
      check("to_gap2_busy", busy, 1);
      cyc();
      check("to_idle_busy", busy, 0);
      cyc();
      check("to_next_grant", grant, 4'b0010);
      beat(1, 8'h90, 1'b1, 1'b1, "to1");
      bus.req = 4'b0000;
      setd(1, 8'h00, 1'b0);
      gap_chk(1'b0, "to");
`else
      for (int i = 0; i < 10; i++) begin
         #1;
         check("ns_stall_grant", grant, 1);
         check("ns_stall_valid", bus.tx_valid, 0);
         check("ns_stall_abort", abort, 0);
         check("ns_stall_busy", busy, 1);
         cyc();
      end
      bus.req = 4'b0001;
      beat(0, 8'h81, 1'b1, 1'b1, "ns1");
      bus.req = 4'b0000;
      setd(0, 8'h00, 1'b0);
      gap_chk(1'b0, "ns");
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
